// File: rtl/fifo_arb_pkg.sv
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types and constants for the FIFO write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  // Arbiter FSM: IDLE arbitrates, LOCKED holds the grant for a packet owner
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of each per-requester accepted-word statistics counter
  localparam int STAT_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin search. Starting at prio_ptr and
//                wrapping from NUM_REQ-1 to 0, grants the first asserted
//                request. With no request, grant is zero and index = prio_ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] prio_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  // Walk the requests in priority order and take the first one found
  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = prio_ptr;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(prio_ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_WIDTH'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Packet-aware round-robin arbiter funnelling NUM_REQ write
//                requesters into one shared synchronous FIFO. A requester
//                that starts a multi-word packet keeps the grant until it
//                sends the word marked last.
//  Options     : FIFO_WR_ARB_STATS_EN - adds per-requester saturating
//                accepted-word counters on output word_count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_CNT_W-1:0] word_count
`endif
);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] prio_ptr_q, prio_ptr_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;

  logic [NUM_REQ-1:0]  rr_grant;
  logic [ID_WIDTH-1:0] rr_idx;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic [NUM_REQ-1:0]  accept_vec;
  logic                gnt_last;

  // Next requester index after i, wrapping at NUM_REQ-1
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    else                        return i + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req       (req_valid),
    .prio_ptr  (prio_ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Current grant: the locked owner, otherwise the round-robin winner
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = rr_idx;
    if (state_q == LOCKED) begin
      gnt_onehot[owner_q] = 1'b1;
      gnt_idx             = owner_q;
    end else begin
      gnt_onehot = rr_grant;
    end
  end

  assign req_ready  = fifo_full ? '0 : gnt_onehot;
  assign accept_vec = req_valid & req_ready;
  assign fifo_w_en  = |accept_vec;
  assign grant_id   = gnt_idx;
  assign busy       = (state_q == LOCKED);

  // Route the granted requester's word and end-of-packet flag to the FIFO
  always_comb begin
    fifo_data_in = '0;
    gnt_last     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_WIDTH'(i)) begin
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_last     = req_last[i];
      end
    end
  end

  // FSM next state: state only moves on an accepted word, so a full FIFO
  // or a stalled owner simply holds everything
  always_comb begin
    state_d    = state_q;
    prio_ptr_d = prio_ptr_q;
    owner_d    = owner_q;
    if (fifo_w_en) begin
      case (state_q)
        IDLE: begin
          if (gnt_last) begin
            prio_ptr_d = wrap_inc(gnt_idx);
          end else begin
            state_d = LOCKED;
            owner_d = gnt_idx;
          end
        end
        LOCKED: begin
          if (gnt_last) begin
            state_d    = IDLE;
            prio_ptr_d = wrap_inc(owner_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, priority pointer and owner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_ptr_q <= '0;
      owner_q    <= '0;
    end else begin
      state_q    <= state_d;
      prio_ptr_q <= prio_ptr_d;
      owner_q    <= owner_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word_cnt
    logic [STAT_CNT_W-1:0] cnt_q;

    // Saturating count of words accepted from requester i
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (accept_vec[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign word_count[i*STAT_CNT_W +: STAT_CNT_W] = cnt_q;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed bench for fifo_wr_arbiter. Expected FIFO writes
//                ({grant id, data}) are queued as stimulus is applied; a
//                monitor pops and compares every FIFO write.
//  Options     : FIFO_WR_ARB_STATS_EN - also exercises word_count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int IDW     = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic              fifo_full;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_data_in;
  logic [IDW-1:0]    grant_id;
  logic              busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] word_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [IDW+DW-1:0] exp_q[$];

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IDW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .word_count   (word_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input int id, input logic [DW-1:0] d);
    exp_q.push_back({IDW'(id), d});
  endtask

  task automatic drive(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] l);
    req_valid = v;
    req_last  = l;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every FIFO write must match the oldest expected write
  always @(negedge clk) begin
    logic [IDW+DW-1:0] e;
    checks++;
    if (fifo_w_en && fifo_full) begin
      errors++;
      $display("FAIL write_while_full: fifo_w_en=1 with fifo_full=1");
    end
    if (fifo_w_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got id %0d data %0h, none expected", grant_id, fifo_data_in);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", 32'(fifo_data_in), 32'(e[DW-1:0]));
        chk("wr_id", 32'(grant_id), 32'(e[IDW+DW-1:DW]));
      end
    end
  end

  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state with no valids
    sample();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wen", 32'(fifo_w_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    rst_n = 1'b1;
    tick();

    // All valid, single-word packets: grant rotates 0,1,2,3,0,1,2,3
    for (int i = 0; i < NUM_REQ; i++) set_word(i, DW'(8'hA0 + i));
    drive(4'hF, 4'hF);
    for (int c = 0; c < 8; c++) begin
      expect_wr(c % 4, DW'(8'hA0 + (c % 4)));
      sample();
      chk("rr_gid", 32'(grant_id), 32'(c % 4));
      tick();
    end

    // Move pointer to 1 with a single word from requester 0
    drive(4'h1, 4'h1);
    expect_wr(0, 8'hA0);
    sample();
    tick();

    // Requester 1 sends AA,BB,CC while 0 and 2 are also valid
    set_word(1, 8'hAA);
    drive(4'h7, 4'h5);
    expect_wr(1, 8'hAA);
    sample();
    chk("pkt_aa_busy", 32'(busy), 32'h0);
    chk("pkt_aa_gid", 32'(grant_id), 32'h1);
    tick();
    set_word(1, 8'hBB);
    expect_wr(1, 8'hBB);
    sample();
    chk("pkt_bb_busy", 32'(busy), 32'h1);
    chk("pkt_bb_gid", 32'(grant_id), 32'h1);
    tick();
    set_word(1, 8'hCC);
    drive(4'h7, 4'h7);
    expect_wr(1, 8'hCC);
    sample();
    chk("pkt_cc_busy", 32'(busy), 32'h1);
    tick();
    drive(4'h5, 4'h5);
    expect_wr(2, 8'hA2);
    sample();
    chk("after_pkt_gid", 32'(grant_id), 32'h2);
    chk("after_pkt_busy", 32'(busy), 32'h0);
    tick();

    // Owner 2 locks, then FIFO full for 3 cycles mid-packet
    set_word(2, 8'h21);
    drive(4'h4, 4'h0);
    expect_wr(2, 8'h21);
    sample();
    tick();
    set_word(2, 8'h22);
    drive(4'h5, 4'h0);
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("full_wen", 32'(fifo_w_en), 32'h0);
      chk("full_ready", 32'(req_ready), 32'h0);
      chk("full_busy", 32'(busy), 32'h1);
      chk("full_gid", 32'(grant_id), 32'h2);
      tick();
    end
    fifo_full = 1'b0;
    expect_wr(2, 8'h22);
    sample();
    chk("unfull_ready", 32'(req_ready), 32'h4);
    tick();
    // Owner drops valid: lock kept, no write even though req 0 is valid
    drive(4'h1, 4'h1);
    sample();
    chk("stall_wen", 32'(fifo_w_en), 32'h0);
    chk("stall_busy", 32'(busy), 32'h1);
    chk("stall_gid", 32'(grant_id), 32'h2);
    tick();
    set_word(2, 8'h23);
    drive(4'h5, 4'h4);
    expect_wr(2, 8'h23);
    sample();
    tick();

    // Only requester 3 valid: pointer 3 -> 0, then wrap-search each cycle
    set_word(3, 8'h33);
    drive(4'h8, 4'h8);
    expect_wr(3, 8'h33);
    sample();
    tick();
    for (int c = 0; c < 3; c++) begin
      expect_wr(3, 8'h33);
      sample();
      chk("wrap_gid", 32'(grant_id), 32'h3);
      chk("wrap_ready", 32'(req_ready), 32'h8);
      tick();
    end
    drive(4'h0, 4'h0);
    sample();
    chk("idle_gid_ptr", 32'(grant_id), 32'h0);
    chk("idle_ready", 32'(req_ready), 32'h0);
    tick();

    // Lock owner 3, then reset mid-packet
    drive(4'h8, 4'h0);
    expect_wr(3, 8'h33);
    sample();
    tick();
    fifo_full = 1'b1;
    sample();
    chk("lock3_busy", 32'(busy), 32'h1);
    chk("lock3_gid", 32'(grant_id), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_word(i, DW'(8'hA0 + i));
    drive(4'hF, 4'hF);
    expect_wr(0, 8'hA0);
    sample();
    chk("post_rst_gid", 32'(grant_id), 32'h0);
    tick();
    drive(4'h0, 4'h0);

`ifdef FIFO_WR_ARB_STATS_EN
    // Statistics: fresh reset, 5 words from req 2, then saturate req 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_word(2, 8'h55);
    drive(4'h4, 4'h4);
    for (int c = 0; c < 5; c++) begin
      expect_wr(2, 8'h55);
      tick();
    end
    drive(4'h0, 4'h0);
    sample();
    chk("cnt2", 32'(word_count[2*16 +: 16]), 32'd5);
    chk("cnt0", 32'(word_count[0 +: 16]), 32'd0);
    chk("cnt1", 32'(word_count[16 +: 16]), 32'd0);
    chk("cnt3", 32'(word_count[3*16 +: 16]), 32'd0);
    tick();
    set_word(1, 8'h11);
    drive(4'h2, 4'h2);
    for (int c = 0; c < 70000; c++) begin
      expect_wr(1, 8'h11);
      tick();
    end
    drive(4'h0, 4'h0);
    sample();
    chk("cnt1_sat", 32'(word_count[16 +: 16]), 32'hFFFF);
    chk("cnt2_hold", 32'(word_count[2*16 +: 16]), 32'd5);
    tick();
`endif

    repeat (2) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
